// File: rtl/blake256_avalon_slave.sv
// ----------------------------------------------------------------------------
// blake256_avalon_slave
// Avalon-MM slave around a single-block BLAKE-256 core (14 rounds, 256-bit
// digest). Software writes the message length in bits (0..447) and the
// big-endian message words. Hardware pads and compresses one 512-bit block,
// then exposes the digest.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   address     word address (5 bits)
//   writedata   write data (32 bits)
//   byteenable  per-byte write enables
//   write/read  strobes, qualified by chipselect
//   chipselect  slave select
//   readdata    combinational read data (latency 0)
//
// Optional feature: define BLAKE_SALT_EN to add writable salt words S0..S3 at
// 0x18..0x1B. Without it the salt is constant zero and those addresses read 0.
// ----------------------------------------------------------------------------
module blake256_avalon_slave #(
   parameter logic [31:0] ID_VALUE = 32'hB1A4_0256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  address,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   input  logic        write,
   input  logic        read,
   input  logic        chipselect,
   output logic [31:0] readdata
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   typedef struct packed {logic [31:0] a, b, c, d;} quad_t;

   localparam logic [31:0] IV [8] = '{
      32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
      32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
   localparam logic [31:0] CST [16] = '{
      32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
      32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
      32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
      32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917};
   localparam logic [4:0] LAST_STEP = 5'd28;   // 28 half-rounds, then finalize
   localparam logic [8:0] MAX_LEN   = 9'd447;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic quad_t g_fn(input quad_t q, input logic [31:0] mx,
                                  input logic [31:0] my);
      quad_t r;
      r   = q;
      r.a = r.a + r.b + mx;
      r.d = rotr(r.d ^ r.a, 16);
      r.c = r.c + r.d;
      r.b = rotr(r.b ^ r.c, 12);
      r.a = r.a + r.b + my;
      r.d = rotr(r.d ^ r.a, 8);
      r.c = r.c + r.d;
      r.b = rotr(r.b ^ r.c, 7);
      return r;
   endfunction

   // Permutation table, entry j of a row lives in nibble j.
   function automatic logic [3:0] sigma(input logic [3:0] row, input logic [3:0] idx);
      logic [63:0] p;
      case (row)
         4'd1:    p = 64'h357B20C16DF984AE;
         4'd2:    p = 64'h491763EADF250C8B;
         4'd3:    p = 64'h8F04A562EBCD1397;
         4'd4:    p = 64'hD386CB1EFA427509;
         4'd5:    p = 64'h91EF57D438B0A6C2;
         4'd6:    p = 64'hB8293670A4DEF15C;
         4'd7:    p = 64'hA2684F05931CE7BD;
         4'd8:    p = 64'h5A417D2C803B9EF6;
         4'd9:    p = 64'h0DC3E9BF5167482A;
         default: p = 64'hFEDCBA9876543210;
      endcase
      return p[{idx, 2'b00} +: 4];
   endfunction

   state_t            state, state_next;
   logic [8:0]        msglen, len_merged, len_new;
   logic [3:0]        count;
   logic [4:0]        step;
   logic [15:0][31:0] m_q, m_pad, v_q, v_init, v_next;
   logic [7:0][31:0]  digest, h_final;
   logic [3:0][31:0]  salt;
   logic [31:0]       data_masked, len32;
   logic              wr_en, wr_len, wr_data, wr_clr, start_ok, busy, ready;
   logic [3:0]        rnd, srow, ia, ib, ic, id, j0, j1, mi0, mi1;
   quad_t             q_out;

   // ---------------- bus decode ----------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      data_masked = '0;
      wr_en   = write && chipselect;
      wr_len  = wr_en && (address == 5'h00);
      wr_data = wr_en && (address == 5'h01);
      wr_clr  = wr_en && (address == 5'h04);
      // MSGLEN keeps unenabled bytes, then clamps to one padded block
      len_merged = {byteenable[1] ? writedata[8]   : msglen[8],
                    byteenable[0] ? writedata[7:0] : msglen[7:0]};
      len_new    = (len_merged > MAX_LEN) ? MAX_LEN : len_merged;
      for (int b = 0; b < 4; b++)
         data_masked[8*b +: 8] = byteenable[b] ? writedata[8*b +: 8] : 8'h00;
      start_ok = ({1'b0, count, 5'b0} >= {1'b0, msglen});
   end

`ifdef BLAKE_SALT_EN
   logic wr_salt;
   assign wr_salt = wr_en && (address[4:2] == 3'b110) && (state != RUN);
   always_ff @(posedge clk) begin
      if (reset) salt <= '0;
      else if (wr_salt)
         for (int b = 0; b < 4; b++)
            if (byteenable[b]) salt[address[1:0]][8*b +: 8] <= writedata[8*b +: 8];
   end
`else
   always_comb salt = '0;
`endif

   // ---------------- padding, init, finalize ----------------
   always_comb begin
      m_pad = '0;
      len32 = {23'b0, msglen};
      for (int w = 0; w < 14; w++)
         for (int b = 0; b < 32; b++)
            if ((w*32 + 31 - b) < len32)       m_pad[w][b] = m_q[w][b];
            else if ((w*32 + 31 - b) == len32) m_pad[w][b] = 1'b1;
      m_pad[13][0] = 1'b1;          // message bit 447: end-of-padding marker
      m_pad[15]    = len32;         // length low word; m[14] (high word) stays 0

      v_init = '0;
      for (int i = 0; i < 8; i++) v_init[i] = IV[i];
      for (int i = 0; i < 4; i++) v_init[8+i] = salt[i] ^ CST[i];
      v_init[12] = len32 ^ CST[4];
      v_init[13] = len32 ^ CST[5];
      v_init[14] = CST[6];
      v_init[15] = CST[7];

      h_final = '0;
      for (int i = 0; i < 8; i++) h_final[i] = IV[i] ^ salt[i%4] ^ v_q[i] ^ v_q[i+8];
   end

   // ---------------- four G units: even step = columns, odd = diagonals ----
   always_comb begin
      v_next = v_q;
      rnd    = step[4:1];
      srow   = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
      ia = '0; ib = '0; ic = '0; id = '0; j0 = '0; j1 = '0; mi0 = '0; mi1 = '0;
      q_out = '0;
      for (int i = 0; i < 4; i++) begin
         ia  = 4'(i);
         ib  = step[0] ? 4'(4  + (i + 1) % 4) : 4'(4  + i);
         ic  = step[0] ? 4'(8  + (i + 2) % 4) : 4'(8  + i);
         id  = step[0] ? 4'(12 + (i + 3) % 4) : 4'(12 + i);
         j0  = {step[0], 2'(i), 1'b0};
         j1  = {step[0], 2'(i), 1'b1};
         mi0 = sigma(srow, j0);
         mi1 = sigma(srow, j1);
         q_out = g_fn({v_q[ia], v_q[ib], v_q[ic], v_q[id]},
                      m_q[mi0] ^ CST[mi1], m_q[mi1] ^ CST[mi0]);
         v_next[ia] = q_out.a;
         v_next[ib] = q_out.b;
         v_next[ic] = q_out.c;
         v_next[id] = q_out.d;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so all registers update together.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (wr_len)               state_next = LOAD;
         LOAD:    if (start_ok)             state_next = RUN;
         RUN:     if (step == LAST_STEP)    state_next = DONE;
         DONE:    if (wr_clr)               state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   // ---------------- control registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         msglen <= '0;
         count  <= '0;
         step   <= '0;
         digest <= '0;
      end else begin
         case (state)
            IDLE: if (wr_len) begin
               msglen <= len_new;
               count  <= '0;
            end
            LOAD: if (start_ok) begin
               step <= '0;
            end else if (wr_len) begin
               msglen <= len_new;
               count  <= '0;
            end else if (wr_data && count < 4'd14) begin
               count <= count + 4'd1;
            end
            RUN: if (step == LAST_STEP) digest <= h_final;
                 else                   step   <= step + 5'd1;
            default: ;
         endcase
      end
   end

   // Message and working state are always written before use, so they
   // carry no reset.
   always_ff @(posedge clk) begin
      // NOTE: wide datapath arrays are left unreset; only control state needs a known value.
      if (state == LOAD) begin
         if (start_ok) begin
            m_q <= m_pad;
            v_q <= v_init;
         end else if (!wr_len && wr_data && count < 4'd14) begin
            m_q[count] <= data_masked;
         end
      end else if (state == RUN && step != LAST_STEP) begin
         v_q <= v_next;
      end
   end

   // ---------------- read mux ----------------
   assign busy  = (state == RUN);
   assign ready = (state == DONE);

   always_comb begin
      readdata = '0;
      if (read && chipselect) begin
         case (address)
            5'h00: readdata = {30'b0, busy, ready};
            5'h01: readdata = {23'b0, msglen};
            5'h08, 5'h09, 5'h0A, 5'h0B,
            5'h0C, 5'h0D, 5'h0E, 5'h0F: readdata = digest[address[2:0]];
            5'h10: readdata = ID_VALUE;
`ifdef BLAKE_SALT_EN
            5'h18, 5'h19, 5'h1A, 5'h1B: readdata = salt[address[1:0]];
`endif
            default: readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_blake256_avalon_slave.sv
// ----------------------------------------------------------------------------
// tb_blake256_avalon_slave
// Directed bench for blake256_avalon_slave: reset state, register map,
// known-answer digests, start-to-ready timing, busy lockout, byteenable
// masking, length clamp, ready handshake and reset abort.
// ----------------------------------------------------------------------------
module tb_blake256_avalon_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  address = '0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic        chipselect = 1'b0;
   logic [31:0] readdata;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] empty_dig [8] = '{
      32'h716f6e86, 32'h3f744b9a, 32'hc22c97ec, 32'h7b76ea5f,
      32'h5908bc5b, 32'h2f67c615, 32'h10bfc475, 32'h1384ea7a};
   logic [31:0] zero_dig [8] = '{
      32'h0ce8d4ef, 32'h4dd7cd8d, 32'h62dfded9, 32'hd4edb0a7,
      32'h74ae6a41, 32'h929a74da, 32'h23109e8f, 32'h11139c87};

   always #5 clk = ~clk;

   blake256_avalon_slave dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .writedata  (writedata),
      .byteenable (byteenable),
      .write      (write),
      .read       (read),
      .chipselect (chipselect),
      .readdata   (readdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // One write strobe, sampled at a single rising edge; returns 1 ns after it.
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      address = a; writedata = d; byteenable = be;
      write = 1'b1; chipselect = 1'b1; read = 1'b0;
      @(posedge clk);
      #1;
      write = 1'b0; chipselect = 1'b0;
   endtask

   // Combinational read, no clock edge consumed.
   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      address = a; read = 1'b1; chipselect = 1'b1;
      #1;
      d = readdata;
      read = 1'b0; chipselect = 1'b0;
   endtask

   // Polls STATUS once per cycle; cyc = cycles until ready (0 on timeout).
   task automatic wait_ready(output int cyc);
      logic [31:0] s;
      cyc = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         bus_read(5'h00, s);
         if (s[0]) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic check_digest(input string tag, input logic [31:0] exp [8]);
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         bus_read(5'(8 + i), d);
         check($sformatf("%s_h%0d", tag, i), d, exp[i]);
      end
   endtask

   initial begin
      logic [31:0] d;
      int cyc;
      int first;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      bus_read(5'h00, d); check("rst_status", d, 32'h0);
      bus_read(5'h01, d); check("rst_msglen", d, 32'h0);
      bus_read(5'h08, d); check("rst_h0", d, 32'h0);
      bus_read(5'h0F, d); check("rst_h7", d, 32'h0);
      bus_read(5'h10, d); check("id", d, 32'hB1A40256);
      bus_read(5'h05, d); check("unmapped_05", d, 32'h0);
      bus_read(5'h18, d); check("salt0_rst", d, 32'h0);
      address = 5'h10; chipselect = 1'b1; read = 1'b0;
      #1 check("no_read_zero", readdata, 32'h0);
      chipselect = 1'b0;

      // ---- write without chipselect is dropped ----
      @(negedge clk);
      address = 5'h00; writedata = 32'd8; byteenable = 4'hF; write = 1'b1; chipselect = 1'b0;
      @(posedge clk);
      #1 write = 1'b0;
      bus_read(5'h01, d); check("nocs_msglen", d, 32'h0);

      // ---- empty message, 30 cycles from MSGLEN write in IDLE ----
      bus_write(5'h00, 32'd0, 4'hF);
      wait_ready(cyc);
      check("empty_latency", 32'(cyc), 32'd30);
      bus_read(5'h00, d); check("empty_status", d, 32'h1);
      check_digest("empty", empty_dig);

      // ---- handshake ----
      bus_write(5'h04, 32'h0, 4'hF);
      bus_read(5'h00, d); check("clr_status", d, 32'h0);
      bus_read(5'h08, d); check("clr_h0_kept", d, empty_dig[0]);

      // ---- one zero byte with timing from the last DATA push ----
      bus_write(5'h00, 32'd8, 4'hF);
      bus_write(5'h01, 32'h00000000, 4'hF);
      first = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         bus_read(5'h00, d);
         if (k == 1)  check("busy_k1", d, 32'h2);
         if (k == 29) check("busy_k29", d, 32'h2);
         if (d[0]) begin
            first = k;
            break;
         end
      end
      check("data_latency", 32'(first), 32'd30);
      bus_read(5'h00, d); check("byte_status", d, 32'h1);
      bus_read(5'h01, d); check("byte_msglen", d, 32'd8);
      check_digest("byte", zero_dig);
      bus_write(5'h04, 32'h0, 4'hF);

      // ---- busy lockout ----
      bus_write(5'h00, 32'd0, 4'hF);
      bus_write(5'h01, 32'hCC000000, 4'hF);
      bus_write(5'h00, 32'd8, 4'hF);
      bus_read(5'h00, d); check("lock_busy", d, 32'h2);
      wait_ready(cyc);
      bus_read(5'h00, d); check("lock_status", d, 32'h1);
      bus_read(5'h01, d); check("lock_msglen", d, 32'h0);
      check_digest("lock", empty_dig);
      bus_write(5'h01, 32'hCC000000, 4'hF);   // DONE: also dropped
      bus_read(5'h08, d); check("done_drop_h0", d, empty_dig[0]);
      bus_write(5'h04, 32'h0, 4'hF);

      // ---- byteenable on MSGLEN, clamp, byteenable on DATA ----
      bus_write(5'h00, 32'h000001FF, 4'b0001);
      bus_read(5'h01, d); check("be_msglen", d, 32'h0FF);
      bus_write(5'h00, 32'h000001FF, 4'hF);
      bus_read(5'h01, d); check("clamp_msglen", d, 32'h1BF);
      bus_write(5'h00, 32'd8, 4'hF);
      bus_write(5'h01, 32'hFF000000, 4'b0111);   // top byte forced to 0x00
      wait_ready(cyc);
      bus_read(5'h00, d); check("be_status", d, 32'h1);
      check_digest("be", zero_dig);
      bus_write(5'h04, 32'h0, 4'hF);

      // ---- reset during RUN ----
      bus_write(5'h00, 32'd0, 4'hF);
      repeat (5) @(posedge clk);
      #1;
      bus_read(5'h00, d); check("pre_rst_busy", d, 32'h2);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      bus_read(5'h00, d); check("abort_status", d, 32'h0);
      bus_read(5'h08, d); check("abort_h0", d, 32'h0);
      bus_read(5'h0D, d); check("abort_h5", d, 32'h0);
      bus_write(5'h00, 32'd0, 4'hF);
      wait_ready(cyc);
      check("rerun_latency", 32'(cyc), 32'd30);
      check_digest("rerun", empty_dig);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
